video_pattern_gen: RTL and testbench

Synthesizable video source that produces the raster timing (vs/hs/de) and RGB pixel stream consumed by `snn_rgb`. It is the hardware counterpart of the bench stimulus driver, so `snn_rgb` can run on the board without a camera. Raster geometry and the gradient pattern match the simulation stimulus exactly, so captured hardware output can be diffed against simulation output.

---
 rtl/video_pattern_gen.sv | 158 +++++++++++++++
 tb/tb_video_pattern_gen.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/video_pattern_gen.sv
// Board-side video source for snn_rgb: raster timing plus four test patterns.
// Every output is registered, so position (x,y) appears one cycle after the counters hold it.
module video_pattern_gen #(
  parameter int H_RES   = 640,
  parameter int V_RES   = 480,
  parameter int H_BLANK = 100,
  parameter int V_BLANK = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic [1:0]  mode,
  input  logic [7:0]  solid_r,
  input  logic [7:0]  solid_g,
  input  logic [7:0]  solid_b,
  output logic        vs_out,
  output logic        hs_out,
  output logic        de_out,
  output logic [7:0]  r_out,
  output logic [7:0]  g_out,
  output logic [7:0]  b_out,
  output logic        frame_done,
  output logic [15:0] frame_cnt,
  output logic        active
);
  localparam int H_TOT = H_RES + H_BLANK;
  localparam int V_TOT = V_RES + V_BLANK;
  localparam int XW    = $clog2(H_TOT);
  localparam int YW    = (V_TOT > 2) ? $clog2(V_TOT) : 1;
  localparam int BAR_W = H_RES / 8;
  localparam logic [XW-1:0] X_LAST = XW'(H_TOT - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(V_TOT - 1);

  typedef enum logic {ST_IDLE, ST_RUN} state_t;
  typedef enum logic [1:0] {PAT_GRADIENT, PAT_BARS, PAT_SOLID, PAT_CHECKER} pattern_t;

  state_t        state_q, state_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  pattern_t      mode_q, mode_d;
  logic [23:0]   solid_q, solid_d;
  logic          vs_q, vs_d, hs_q, hs_d, de_q, de_d;
  logic [23:0]   rgb_q, rgb_d;
  logic          frame_done_q, frame_done_d;
  logic [15:0]   frame_cnt_q, frame_cnt_d;
  logic          active_q, active_d;

  logic [7:0]  x8, y8, grad_r;
  logic [2:0]  bar_idx;
  logic [23:0] pix;

  // Pattern value for the current counter position; blanking is masked later.
  always_comb begin
    x8      = 8'(x_q);
    y8      = 8'(y_q);
    grad_r  = x8 + y8;
    bar_idx = 3'(x_q / XW'(BAR_W));
    pix     = '0;
    unique case (mode_q)
      PAT_GRADIENT: pix = {grad_r, x8[6:0], 1'b0, y8[6:0], 1'b0};
      // Bar order white..black maps to R=~idx[1], G=~idx[2], B=~idx[0].
      PAT_BARS:     pix = {{8{~bar_idx[1]}}, {8{~bar_idx[2]}}, {8{~bar_idx[0]}}};
      PAT_SOLID:    pix = solid_q;
      PAT_CHECKER:  pix = {24{x8[3] ^ y8[3]}};
    endcase
  end

  // NOTE: every signal assigned in this block gets a default first, so no path leaves a latch.
  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    mode_d       = mode_q;
    solid_d      = solid_q;
    vs_d         = 1'b0;
    hs_d         = 1'b0;
    de_d         = 1'b0;
    rgb_d        = '0;
    frame_done_d = 1'b0;
    active_d     = (state_q == ST_RUN);
    frame_cnt_d  = frame_cnt_q + 16'(frame_done_q);
    unique case (state_q)
      ST_IDLE: begin
        x_d = '0;
        y_d = '0;
        if (enable) begin
          state_d = ST_RUN;
          mode_d  = pattern_t'(mode);
          solid_d = {solid_r, solid_g, solid_b};
        end
      end
      ST_RUN: begin
        vs_d  = (y_q == '0);
        hs_d  = (x_q < XW'(H_RES));
        de_d  = hs_d && (y_q < YW'(V_RES));
        rgb_d = de_d ? pix : '0;
        if (x_q != X_LAST) begin
          x_d = x_q + 1'b1;
        end else begin
          x_d = '0;
          if (y_q != Y_LAST) begin
            y_d = y_q + 1'b1;
          end else begin
            // Frame boundary: the only place enable, mode and colour are looked at.
            y_d          = '0;
            frame_done_d = 1'b1;
            if (enable) begin
              mode_d  = pattern_t'(mode);
              solid_d = {solid_r, solid_g, solid_b};
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
      end
    endcase
  end

  // NOTE: reset is synchronous and state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      x_q          <= '0;
      y_q          <= '0;
      mode_q       <= PAT_GRADIENT;
      solid_q      <= '0;
      vs_q         <= 1'b0;
      hs_q         <= 1'b0;
      de_q         <= 1'b0;
      rgb_q        <= '0;
      frame_done_q <= 1'b0;
      frame_cnt_q  <= '0;
      active_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      mode_q       <= mode_d;
      solid_q      <= solid_d;
      vs_q         <= vs_d;
      hs_q         <= hs_d;
      de_q         <= de_d;
      rgb_q        <= rgb_d;
      frame_done_q <= frame_done_d;
      frame_cnt_q  <= frame_cnt_d;
      active_q     <= active_d;
    end
  end

  assign vs_out                 = vs_q;
  assign hs_out                 = hs_q;
  assign de_out                 = de_q;
  assign {r_out, g_out, b_out}  = rgb_q;
  assign frame_done             = frame_done_q;
  assign frame_cnt              = frame_cnt_q;
  assign active                 = active_q;

endmodule

// File: tb/tb_video_pattern_gen.sv
// Bench for video_pattern_gen: three geometries share one stimulus stream and are
// compared every cycle against a position-index reference model, plus directed spot values.
module tb_video_pattern_gen;
  localparam int NI = 3;
  localparam int OW = 45;

  logic       clk = 1'b0;
  logic       reset_n, enable;
  logic [1:0] mode;
  logic [7:0] solid_r, solid_g, solid_b;

  logic [NI-1:0] vs, hs, de, fd, act;
  logic [7:0]    r [NI];
  logic [7:0]    g [NI];
  logic [7:0]    b [NI];
  logic [15:0]   fc [NI];

  always #5 clk = ~clk;

  video_pattern_gen dut_d (
    .clk(clk), .reset_n(reset_n), .enable(enable), .mode(mode),
    .solid_r(solid_r), .solid_g(solid_g), .solid_b(solid_b),
    .vs_out(vs[0]), .hs_out(hs[0]), .de_out(de[0]),
    .r_out(r[0]), .g_out(g[0]), .b_out(b[0]),
    .frame_done(fd[0]), .frame_cnt(fc[0]), .active(act[0]));

  video_pattern_gen #(.H_RES(256), .V_RES(8), .H_BLANK(8), .V_BLANK(2)) dut_m (
    .clk(clk), .reset_n(reset_n), .enable(enable), .mode(mode),
    .solid_r(solid_r), .solid_g(solid_g), .solid_b(solid_b),
    .vs_out(vs[1]), .hs_out(hs[1]), .de_out(de[1]),
    .r_out(r[1]), .g_out(g[1]), .b_out(b[1]),
    .frame_done(fd[1]), .frame_cnt(fc[1]), .active(act[1]));

  video_pattern_gen #(.H_RES(16), .V_RES(4), .H_BLANK(4), .V_BLANK(2)) dut_s (
    .clk(clk), .reset_n(reset_n), .enable(enable), .mode(mode),
    .solid_r(solid_r), .solid_g(solid_g), .solid_b(solid_b),
    .vs_out(vs[2]), .hs_out(hs[2]), .de_out(de[2]),
    .r_out(r[2]), .g_out(g[2]), .b_out(b[2]),
    .frame_done(fd[2]), .frame_cnt(fc[2]), .active(act[2]));

  int    hres [NI] = '{640, 256, 16};
  int    vres [NI] = '{480, 8, 4};
  int    hblk [NI] = '{100, 8, 4};
  int    vblk [NI] = '{10, 2, 2};
  string name [NI] = '{"dflt", "mid", "small"};
  logic [23:0] bar_tbl [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                               24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  // Model state: position index shown / to be shown next (-1 means idle), frame latches.
  int          shown [NI];
  int          nxt   [NI];
  logic [1:0]  lmode [NI];
  logic [23:0] lsolid[NI];
  logic [15:0] mfc   [NI];
  bit          pfd   [NI];
  int          errors = 0;
  int          checks = 0;
  bit          rnd_solid = 1'b1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, want);
    end
  endtask

  function automatic logic [23:0] ref_pixel(int i, int x, int y);
    if (x >= hres[i] || y >= vres[i]) return 24'h0;
    case (lmode[i])
      2'd0:    return {8'((x + y) % 256), 8'((2 * x) % 256), 8'((2 * y) % 256)};
      2'd1:    return bar_tbl[x / (hres[i] / 8)];
      2'd2:    return lsolid[i];
      default: return ((((x >> 3) ^ (y >> 3)) & 1) != 0) ? 24'hFFFFFF : 24'h0;
    endcase
  endfunction

  function automatic logic [OW-1:0] ref_out(int i, int pos, bit fdn, logic [15:0] fcv);
    int htot, x, y;
    if (pos < 0) return {3'b0, 24'h0, 1'b0, fcv, 1'b0};
    htot = hres[i] + hblk[i];
    x = pos % htot;
    y = pos / htot;
    return {y == 0, x < hres[i], (x < hres[i]) && (y < vres[i]),
            ref_pixel(i, x, y), fdn, fcv, 1'b1};
  endfunction

  function automatic logic [OW-1:0] obs_out(int i);
    return {vs[i], hs[i], de[i], r[i], g[i], b[i], fd[i], fc[i], act[i]};
  endfunction

  // One clock: advance the model with the inputs the DUTs sampled, then compare.
  task automatic step();
    int frame;
    bit fdn;
    logic [OW-1:0] exp_v;
    @(posedge clk);
    #1;
    for (int i = 0; i < NI; i++) begin
      frame = (hres[i] + hblk[i]) * (vres[i] + vblk[i]);
      if (!reset_n) begin
        nxt[i] = -1; shown[i] = -1; mfc[i] = '0; pfd[i] = 1'b0;
        exp_v = '0;
      end else begin
        shown[i] = nxt[i];
        fdn = (shown[i] == frame - 1);
        mfc[i] = mfc[i] + 16'(pfd[i]);
        pfd[i] = fdn;
        exp_v = ref_out(i, shown[i], fdn, mfc[i]);
        if (shown[i] == -1 || fdn) begin
          if (enable) begin
            nxt[i] = 0; lmode[i] = mode; lsolid[i] = {solid_r, solid_g, solid_b};
          end else begin
            nxt[i] = -1;
          end
        end else begin
          nxt[i] = shown[i] + 1;
        end
      end
      check({"model_", name[i]}, 64'(obs_out(i)), 64'(exp_v));
    end
    if (rnd_solid) begin
      solid_r = 8'($urandom); solid_g = 8'($urandom); solid_b = 8'($urandom);
    end
  endtask

  initial begin
    int p, vs_cnt;
    reset_n = 1'b0; enable = 1'b0; mode = 2'd0;
    solid_r = 8'd0; solid_g = 8'd0; solid_b = 8'd0;
    for (int i = 0; i < NI; i++) begin
      shown[i] = -1; nxt[i] = -1; lmode[i] = '0; lsolid[i] = '0; mfc[i] = '0; pfd[i] = 1'b0;
    end
    repeat (3) step();
    for (int i = 0; i < NI; i++) check({"reset_", name[i]}, 64'(obs_out(i)), 64'd0);

    // Start: enable sampled at edge k, (0,0) shown after edge k+1.
    reset_n = 1'b1;
    repeat (2) step();
    check("idle_active", 64'(act), 64'd0);
    enable = 1'b1;
    step();
    check("k_still_blank", 64'({vs[0], hs[0], de[0]}), 64'd0);
    step();
    check("first_px", 64'({vs[0], hs[0], de[0], r[0], g[0], b[0]}), {37'd0, 3'b111, 24'h0});

    vs_cnt = 0;
    for (int n = 0; n < 1483; n++) begin
      p = shown[0];
      if (p < 740 && vs[0]) vs_cnt++;
      if (p == 640) check("blank_x640", 64'({hs[0], de[0], r[0], g[0], b[0]}), 64'd0);
      if (p == 740) check("vs_line1", 64'(vs[0]), 64'd0);
      if (p == 60)  check("s_fd_mid", 64'({fd[2], fc[2]}), {47'd0, 1'b0, 16'd0});
      if (p == 119) check("s_fd_1", 64'({fd[2], fc[2]}), {47'd0, 1'b1, 16'd0});
      if (p == 120) check("s_cnt_1", 64'({fd[2], fc[2]}), {47'd0, 1'b0, 16'd1});
      if (p == 239) check("s_fd_2", 64'({fd[2], fc[2]}), {47'd0, 1'b1, 16'd1});
      if (p == 240) check("s_cnt_2", 64'({fd[2], fc[2]}), {47'd0, 1'b0, 16'd2});
      step();
    end
    check("vs_line0_cnt", 64'(vs_cnt), 64'd740);
    check("px_3_2", 64'({r[0], g[0], b[0]}), 64'h050604);

    // Mode changes mid-frame take effect only at the mid instance's next frame start.
    mode = 2'd1;
    for (int n = 0; n < 11402 - 1483; n++) begin
      p = shown[0];
      if (p == 2000) check("m_still_grad", 64'({r[1], g[1], b[1]}), 64'h9F300E);
      if (p == 2122) check("m_vblank", 64'({hs[1], de[1], r[1], g[1], b[1]}), {38'd0, 2'b10, 24'h0});
      if (p == 2680) check("m_bar1", 64'({r[1], g[1], b[1]}), 64'hFFFF00);
      if (p == 2840) check("m_bar6", 64'({r[1], g[1], b[1]}), 64'h0000FF);
      if (p == 2895) check("m_bar7", 64'({r[1], g[1], b[1]}), 64'h000000);
      if (p == 2900) mode = 2'd3;
      if (p == 3004) check("m_bar_hold", 64'({r[1], g[1], b[1]}), 64'h00FF00);
      if (p == 3900) check("d_px_200_5", 64'({r[0], g[0], b[0]}), 64'hCD900A);
      if (p == 5280) check("m_chk_0_0", 64'({r[1], g[1], b[1]}), 64'h000000);
      if (p == 5288) check("m_chk_8_0", 64'({r[1], g[1], b[1]}), 64'hFFFFFF);
      if (p == 5300) begin
        mode = 2'd2; rnd_solid = 1'b0;
        solid_r = 8'd12; solid_g = 8'd34; solid_b = 8'd56;
      end
      if (p == 8189) check("m_solid", 64'({r[1], g[1], b[1]}), 64'h0C2238);
      if (p == 8200) begin solid_r = 8'd99; solid_g = 8'd99; solid_b = 8'd99; end
      if (p == 9440) check("m_solid_hold", 64'({r[1], g[1], b[1]}), 64'h0C2238);
      step();
    end

    // One-cycle reset while the mid instance is on line 3.
    check("m_line3", 64'(shown[1] / 264), 64'd3);
    reset_n = 1'b0;
    step();
    for (int i = 0; i < NI; i++) check({"rst_mid_", name[i]}, 64'(obs_out(i)), 64'd0);
    reset_n = 1'b1;
    step();
    step();
    check("restart_d", 64'({vs[0], hs[0], de[0]}), 64'd7);
    check("restart_m", 64'({vs[1], hs[1], de[1], fc[1]}), {45'd0, 3'b111, 16'd0});

    // Drop enable at cycle 30 of a small frame: frame completes, then idle.
    for (int n = 0; n < 200 && shown[2] != 30; n++) step();
    check("s_at_30", 64'(shown[2]), 64'd30);
    enable = 1'b0;
    for (int n = 0; n < 200 && shown[2] != 119; n++) step();
    check("s_stop_fd", 64'({fd[2], act[2]}), 64'd3);
    step();
    check("s_idle", 64'(obs_out(2)), {19'd0, 3'b0, 24'h0, 1'b0, 16'd1, 1'b0});
    repeat (5) step();
    check("s_idle_hold", 64'({act[2], vs[2], hs[2], de[2], fd[2]}), 64'd0);

    // Randomized phase: enable, mode, colours and occasional resets.
    rnd_solid = 1'b1;
    for (int n = 0; n < 6000; n++) begin
      enable  = ($urandom_range(0, 3) != 0);
      reset_n = ($urandom_range(0, 1999) != 0);
      if ($urandom_range(0, 63) == 0) mode = 2'($urandom);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
